// File: rtl/mux_seq_pkg.sv
// Shared constants and FSM state type for the 64:1 mux round-robin sequencer.
package mux_seq_pkg;

    localparam int N_REQ = 64;
    localparam int SEL_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick64.sv
// Round-robin pick: rotate req so the search starts at ptr+1, then priority-encode the lowest set bit.
module rr_pick64
    import mux_seq_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] off;
    logic [N_REQ-1:0] rot;

    assign start = ptr + 1'b1;
    // Doubling req makes the right shift behave as a rotate; bit 0 of rot is requester 'start'.
    assign rot   = N_REQ'({req, req} >> start);
    assign any   = |req;
    assign win   = start + off;

    always_comb begin
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/mux_64x1_rr_sequencer.sv
// Round-robin sequencer that owns the select of a shared 64:1 mux and forwards sampled bits downstream.
// Optional macro MUX_SEQ_TIMEOUT_EN aborts a transaction stalled in WAIT for TIMEOUT cycles.
module mux_64x1_rr_sequencer
    import mux_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             y,
    output logic [SEL_W-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [SEL_W-1:0] out_idx,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic             timeout_err
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             req_any;
    logic [SEL_W-1:0] win;

    rr_pick64 u_pick (
        .req (req),
        .ptr (ptr),
        .any (req_any),
        .win (win)
    );

    assign busy = (state != IDLE);

`ifdef MUX_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_idx   <= '0;
            ack       <= '0;
            ptr       <= SEL_W'(N_REQ - 1);
`ifdef MUX_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef MUX_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        s     <= win;
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // s was registered last cycle, so y has had a full cycle to settle.
                    out_data  <= y;
                    out_idx   <= s;
                    out_valid <= 1'b1;
                    state     <= WAIT;
`ifdef MUX_SEQ_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (out_ready) begin
                        ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << out_idx;
                        ptr       <= out_idx;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef MUX_SEQ_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Stalled requester drops to lowest priority so others get through.
                        out_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                        ptr         <= out_idx;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_64x1_rr_sequencer.sv
// Directed bench for mux_64x1_rr_sequencer with a behavioural 64:1 mux (y = data[s]).
module tb_mux_64x1_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic        y;
    logic [5:0]  s;
    logic        out_valid;
    logic        out_ready;
    logic        out_data;
    logic [5:0]  out_idx;
    logic [63:0] ack;
    logic        busy;
    logic        timeout_err;
    logic [63:0] data;

    int passed = 0;
    int total  = 0;
    bit ok;

    mux_64x1_rr_sequencer #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .y           (y),
        .s           (s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    assign y = data[s];

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; out_ready = 1'b0; data = '0;
        repeat (3) cyc();
        total++; if (s !== 6'd0) $display("FAIL reset_s: got %0d want 0", s); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 1'b0) $display("FAIL reset_data: got %b want 0", out_data); else passed++;
        total++; if (out_idx !== 6'd0) $display("FAIL reset_idx: got %0d want 0", out_idx); else passed++;
        total++; if (ack !== 64'd0) $display("FAIL reset_ack: got %h want 0", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL reset_terr: got %b want 0", timeout_err); else passed++;
    endtask

    task automatic test_single();
        rst = 1'b0; req = 64'h1; data = 64'h1; out_ready = 1'b1;
        cyc();
        total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", out_valid); else passed++;
        total++; if (s !== 6'd0) $display("FAIL single_s: got %0d want 0", s); else passed++;
        cyc();
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_data !== 1'b1) $display("FAIL single_data: got %b want 1", out_data); else passed++;
        total++; if (out_idx !== 6'd0) $display("FAIL single_idx: got %0d want 0", out_idx); else passed++;
        req = '0;
        cyc();
        total++; if (ack !== 64'h1) $display("FAIL single_ack: got %h want 1", ack); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", out_valid); else passed++;
        cyc();
        total++; if (ack !== 64'h0) $display("FAIL single_ack_clear: got %h want 0", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_round_robin();
        int exp_idx [4] = '{3, 10, 63, 3};
        data = 64'h8000_0000_0000_0008;
        req  = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            total++; if (!ok) $display("FAIL rr_valid_timeout: grant %0d never valid", k); else passed++;
            total++; if (out_idx !== 6'(exp_idx[k])) $display("FAIL rr_idx: grant %0d got %0d want %0d", k, out_idx, exp_idx[k]); else passed++;
            total++; if (out_data !== data[exp_idx[k]]) $display("FAIL rr_data: grant %0d got %b want %b", k, out_data, data[exp_idx[k]]); else passed++;
            if (k == 3) req = '0;
            cyc();
            total++; if (ack !== (64'd1 << exp_idx[k])) $display("FAIL rr_ack: grant %0d got %h want %h", k, ack, 64'd1 << exp_idx[k]); else passed++;
            cyc();
            total++; if (ack !== 64'd0) $display("FAIL rr_ack_pulse: grant %0d got %h want 0", k, ack); else passed++;
        end
    endtask

    task automatic test_wrap();
        data = 64'h1;
        req  = 64'd1 << 63;
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd63) $display("FAIL wrap_first: got %0d want 63", out_idx); else passed++;
        cyc();
        req = (64'd1 << 63) | 64'd1;
        cyc();
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd0) $display("FAIL wrap_to_0: got %0d want 0", out_idx); else passed++;
        total++; if (out_data !== 1'b1) $display("FAIL wrap_data: got %b want 1", out_data); else passed++;
        cyc();
        total++; if (ack !== 64'h1) $display("FAIL wrap_ack0: got %h want 1", ack); else passed++;
        cyc();
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd63) $display("FAIL wrap_back_63: got %0d want 63", out_idx); else passed++;
        req = '0;
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        data = '0;
        req  = 64'd1 << 5;
        wait_valid(ok);
        total++; if (!ok || out_data !== 1'b0) $display("FAIL bp_data0: got %b want 0", out_data); else passed++;
        req = '0;
        for (int k = 0; k < 5; k++) begin
            data = data ^ (64'd1 << 5);
            cyc();
            total++; if (out_valid !== 1'b1 || out_data !== 1'b0 || s !== 6'd5 || ack !== 64'd0)
                $display("FAIL bp_hold: cycle %0d valid=%b data=%b s=%0d ack=%h want 1/0/5/0", k, out_valid, out_data, s, ack);
            else passed++;
        end
        out_ready = 1'b1;
        cyc();
        total++; if (ack !== (64'd1 << 5)) $display("FAIL bp_ack: got %h want %h", ack, 64'd1 << 5); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else passed++;
        cyc();
    endtask

    task automatic test_reset_in_wait();
        out_ready = 1'b0;
        req = 64'd1 << 7;
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd7) $display("FAIL rstw_idx: got %0d want 7", out_idx); else passed++;
        rst = 1'b1;
        cyc();
        total++; if (out_valid !== 1'b0 || ack !== 64'd0 || busy !== 1'b0)
            $display("FAIL rstw_abort: valid=%b ack=%h busy=%b want 0/0/0", out_valid, ack, busy);
        else passed++;
        rst = 1'b0;
        req = 64'd1 | (64'd1 << 5);
        out_ready = 1'b1;
        cyc();
        total++; if (ack !== 64'd0) $display("FAIL rstw_no_ack: got %h want 0", ack); else passed++;
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd0) $display("FAIL rstw_next: got %0d want 0", out_idx); else passed++;
        req = '0;
        cyc();
        total++; if (ack !== 64'h1) $display("FAIL rstw_ack: got %h want 1", ack); else passed++;
        cyc();
    endtask

`ifdef MUX_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0;
        req = (64'd1 << 2) | (64'd1 << 4);
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd2) $display("FAIL to_first: got %0d want 2", out_idx); else passed++;
        for (int k = 0; k < 15; k++) begin
            cyc();
            total++; if (timeout_err !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL to_early: cycle %0d terr=%b valid=%b want 0/1", k, timeout_err, out_valid);
            else passed++;
        end
        cyc();
        total++; if (timeout_err !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_err); else passed++;
        total++; if (out_valid !== 1'b0 || ack !== 64'd0) $display("FAIL to_abort: valid=%b ack=%h want 0/0", out_valid, ack); else passed++;
        out_ready = 1'b1;
        cyc();
        total++; if (timeout_err !== 1'b0) $display("FAIL to_pulse_len: got %b want 0", timeout_err); else passed++;
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd4) $display("FAIL to_next: got %0d want 4", out_idx); else passed++;
        req = '0;
        cyc();
        total++; if (ack !== (64'd1 << 4)) $display("FAIL to_ack: got %h want %h", ack, 64'd1 << 4); else passed++;
        cyc();
    endtask
`else
    task automatic test_no_timeout();
        out_ready = 1'b0;
        req = 64'd1 << 9;
        wait_valid(ok);
        total++; if (!ok || out_idx !== 6'd9) $display("FAIL nto_idx: got %0d want 9", out_idx); else passed++;
        req = '0;
        repeat (24) cyc();
        total++; if (out_valid !== 1'b1 || timeout_err !== 1'b0)
            $display("FAIL nto_hold: valid=%b terr=%b want 1/0", out_valid, timeout_err);
        else passed++;
        out_ready = 1'b1;
        cyc();
        total++; if (ack !== (64'd1 << 9)) $display("FAIL nto_ack: got %h want %h", ack, 64'd1 << 9); else passed++;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_in_wait();
`ifdef MUX_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
